// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. A host streams bytes in. Every three
// bytes form one 24-bit instruction word (first byte is the most significant),
// which is written to consecutive instruction-memory addresses starting at
// BASE_ADDR. After the last word, one more byte arrives and is compared with
// the XOR of all data bytes. The core is held in reset (cpu_hold) for the whole
// load and is released only when that checksum matches.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low (asserted at 0)
//   start         single-cycle load request (honoured in IDLE, DONE, ERR)
//   count         instructions to load, sampled on an accepted start
//   in_data       load byte
//   in_valid      in_data is valid
//   in_ready      loader accepts in_data this cycle
//   imem_wr_en    instruction memory write strobe, one cycle per word
//   imem_wr_addr  instruction memory write address
//   imem_wr_data  instruction word
//   cpu_hold      core reset request, 1 = hold the core
//   busy          load in progress
//   done          load finished with a good checksum (level)
//   chk_err       checksum mismatch (level)
//   len_err       illegal count requested (level)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [23:0]       imem_wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic              len_err
);

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Largest legal count is the full memory depth.
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   index;
    logic [ADDR_W:0]   index_inc;
    logic [7:0]        xor_acc;
    logic [7:0]        byte0;
    logic [7:0]        byte1;
    logic              start_ok;
    logic              len_bad;
    logic              byte_take;
    logic              last_word;

    // Helper terms shared by next-state and datapath logic. in_ready is only
    // ever 1 in a byte-consuming state, so a handshake implies such a state.
    always_comb begin
        start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        len_bad   = (count == '0) || (count > MAX_COUNT);
        byte_take = in_valid && in_ready;
        index_inc = index + ONE;
        last_word = (index_inc == count_q);
    end

    // Next-state logic. Three byte states assemble a word, WRITE spends one
    // cycle on the memory strobe, CHK waits for the checksum byte.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_ok) begin
                    next_state = len_bad ? ERR : B0;
                end
            end
            B0: begin
                if (byte_take) begin
                    next_state = B1;
                end
            end
            B1: begin
                if (byte_take) begin
                    next_state = B2;
                end
            end
            B2: begin
                if (byte_take) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? CHK : B0;
            end
            CHK: begin
                if (byte_take) begin
                    next_state = (in_data == xor_acc) ? DONE : ERR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and datapath. Strobe-like outputs are decoded from
    // next_state so they line up with the state they describe. Address and
    // data are captured on the B2 accept so they are stable throughout WRITE
    // and then simply hold until the next word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            chk_err      <= 1'b0;
            len_err      <= 1'b0;
            count_q      <= '0;
            index        <= '0;
            xor_acc      <= '0;
            byte0        <= '0;
            byte1        <= '0;
        end else begin
            in_ready   <= (next_state == B0) || (next_state == B1) ||
                          (next_state == B2) || (next_state == CHK);
            imem_wr_en <= (next_state == WRITE);
            busy       <= (next_state == B0) || (next_state == B1) ||
                          (next_state == B2) || (next_state == WRITE) ||
                          (next_state == CHK);

            if (start_ok) begin
                count_q  <= count;
                index    <= '0;
                xor_acc  <= '0;
                done     <= 1'b0;
                chk_err  <= 1'b0;
                len_err  <= len_bad;
                cpu_hold <= 1'b1;
            end

            if (byte_take && (state != CHK)) begin
                xor_acc <= xor_acc ^ in_data;
            end

            if (byte_take && (state == B0)) begin
                byte0 <= in_data;
            end

            if (byte_take && (state == B1)) begin
                byte1 <= in_data;
            end

            if (byte_take && (state == B2)) begin
                imem_wr_data <= {byte0, byte1, in_data};
                imem_wr_addr <= BASE_ADDR + index[ADDR_W-1:0];
            end

            if (state == WRITE) begin
                index <= index_inc;
            end

            if (byte_take && (state == CHK)) begin
                if (in_data == xor_acc) begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end else begin
                    chk_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives two loaders from the same byte stream. One has BASE_ADDR 0 and the
// other has BASE_ADDR 8'hFF, so every load also exercises address wrap. For
// each load, the expected writes and the final status are computed from the
// byte list alone. These are the addresses base+i, the words taken from
// consecutive byte triples, and whether the XOR of the bytes matches the
// checksum.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] count;
    logic [7:0] in_data;
    logic       in_valid;

    logic        in_ready     [2];
    logic        imem_wr_en   [2];
    logic [7:0]  imem_wr_addr [2];
    logic [23:0] imem_wr_data [2];
    logic        cpu_hold     [2];
    logic        busy         [2];
    logic        done         [2];
    logic        chk_err      [2];
    logic        len_err      [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0]  stim_bytes [0:767];
    logic [7:0]  got_addr0 [$];
    logic [7:0]  got_addr1 [$];
    logic [23:0] got_data0 [$];
    logic [23:0] got_data1 [$];
    bit          gap_en;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .count        (count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready[0]),
        .imem_wr_en   (imem_wr_en[0]),
        .imem_wr_addr (imem_wr_addr[0]),
        .imem_wr_data (imem_wr_data[0]),
        .cpu_hold     (cpu_hold[0]),
        .busy         (busy[0]),
        .done         (done[0]),
        .chk_err      (chk_err[0]),
        .len_err      (len_err[0])
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFF)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .count        (count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready[1]),
        .imem_wr_en   (imem_wr_en[1]),
        .imem_wr_addr (imem_wr_addr[1]),
        .imem_wr_data (imem_wr_data[1]),
        .cpu_hold     (cpu_hold[1]),
        .busy         (busy[1]),
        .done         (done[1]),
        .chk_err      (chk_err[1]),
        .len_err      (len_err[1])
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expected value and reports a
    // mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Records every write strobe. The loaders must never offer to take a
    // byte while they are writing.
    always @(negedge clk) begin
        if (reset) begin
            if (imem_wr_en[0]) begin
                got_addr0.push_back(imem_wr_addr[0]);
                got_data0.push_back(imem_wr_data[0]);
                checkOutput("ready_in_write0", {31'd0, in_ready[0]}, 32'd0);
            end
            if (imem_wr_en[1]) begin
                got_addr1.push_back(imem_wr_addr[1]);
                got_data1.push_back(imem_wr_data[1]);
                checkOutput("ready_in_write1", {31'd0, in_ready[1]}, 32'd0);
            end
        end
    end

    // XOR of the first 3*n stimulus bytes.
    function automatic logic [7:0] xorOf(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 3 * n; i++) begin
            x ^= stim_bytes[i];
        end
        return x;
    endfunction

    // Presents one byte, optionally after a random idle gap, and holds it
    // until it is accepted. It returns just after the accepting edge. When
    // poke is set, start is also pulsed on the first cycle of the call.
    task automatic sendByte(input logic [7:0] b, input bit poke);
        bit first = 1'b1;
        bit taken = 1'b0;
        if (gap_en && ($urandom_range(0, 2) == 0)) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = poke;
            first    = 1'b0;
        end
        for (int t = 0; t < 40 && !taken; t++) begin
            @(negedge clk);
            start    = poke && first;
            first    = 1'b0;
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready[0]) begin
                @(posedge clk);
                taken = 1'b1;
            end
        end
        if (!taken) begin
            checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    // Runs one load of n words from stim_bytes with checksum chk and then
    // checks both loaders against the expected writes and status. If
    // abort_after is non-zero, reset is asserted after that many bytes and
    // the reset values are checked instead.
    task automatic applyStimulus(input int n, input logic [7:0] chk,
                                 input bit poke_busy, input int abort_after);
        logic [7:0] base;
        bit         good;
        got_addr0.delete();
        got_addr1.delete();
        got_data0.delete();
        got_data1.delete();
        @(negedge clk);
        start = 1'b1;
        count = n[8:0];
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3 * n; i++) begin
            if (poke_busy && i == 1) begin
                count = 9'd1;
            end
            sendByte(stim_bytes[i], poke_busy && (i == 1));
            if (abort_after != 0 && abort_after == i + 1) begin
                #2;
                reset = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    checkOutput("abort_cpu_hold", {31'd0, cpu_hold[d]}, 32'd1);
                    checkOutput("abort_in_ready", {31'd0, in_ready[d]}, 32'd0);
                    checkOutput("abort_busy", {31'd0, busy[d]}, 32'd0);
                    checkOutput("abort_wr_en", {31'd0, imem_wr_en[d]}, 32'd0);
                    checkOutput("abort_addr", {24'd0, imem_wr_addr[d]}, 32'd0);
                    checkOutput("abort_data", {8'd0, imem_wr_data[d]}, 32'd0);
                    checkOutput("abort_done", {31'd0, done[d]}, 32'd0);
                end
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        count = n[8:0];
        sendByte(chk, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        good = (xorOf(n) == chk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("done", {31'd0, done[d]}, {31'd0, good});
            checkOutput("chk_err", {31'd0, chk_err[d]}, {31'd0, !good});
            checkOutput("cpu_hold", {31'd0, cpu_hold[d]}, {31'd0, !good});
            checkOutput("busy", {31'd0, busy[d]}, 32'd0);
            checkOutput("len_err", {31'd0, len_err[d]}, 32'd0);
        end
        checkOutput("write_count0", got_addr0.size(), n);
        checkOutput("write_count1", got_addr1.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] w;
            w = {stim_bytes[3*i], stim_bytes[3*i+1], stim_bytes[3*i+2]};
            if (i < got_addr0.size()) begin
                base = 8'h00 + 8'(i);
                checkOutput("write0", {got_addr0[i], got_data0[i]}, {base, w});
            end
            if (i < got_addr1.size()) begin
                base = 8'hFF + 8'(i);
                checkOutput("write1", {got_addr1[i], got_data1[i]}, {base, w});
            end
        end
    endtask

    // Requests an illegal count and checks that nothing is loaded.
    task automatic applyLenErr(input int n);
        got_addr0.delete();
        got_addr1.delete();
        got_data0.delete();
        got_data1.delete();
        @(negedge clk);
        start = 1'b1;
        count = n[8:0];
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int d = 0; d < 2; d++) begin
            checkOutput("len_err", {31'd0, len_err[d]}, 32'd1);
            checkOutput("len_done", {31'd0, done[d]}, 32'd0);
            checkOutput("len_cpu_hold", {31'd0, cpu_hold[d]}, 32'd1);
        end
        repeat (3) begin
            @(negedge clk);
            checkOutput("len_in_ready", {31'd0, in_ready[0]}, 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("len_writes", got_addr0.size() + got_addr1.size(), 0);
    endtask

    // Loads the basic two-word program: 1A2B3C, 400005.
    task automatic loadBasic();
        stim_bytes[0] = 8'h1A;
        stim_bytes[1] = 8'h2B;
        stim_bytes[2] = 8'h3C;
        stim_bytes[3] = 8'h40;
        stim_bytes[4] = 8'h00;
        stim_bytes[5] = 8'h05;
    endtask

    // Top-level sequence: reset values, directed loads, then random loads.
    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        count    = '0;
        in_data  = '0;
        in_valid = 1'b0;
        gap_en   = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_cpu_hold", {31'd0, cpu_hold[d]}, 32'd1);
            checkOutput("rst_in_ready", {31'd0, in_ready[d]}, 32'd0);
            checkOutput("rst_busy", {31'd0, busy[d]}, 32'd0);
            checkOutput("rst_flags", {29'd0, done[d], chk_err[d], len_err[d]}, 32'd0);
            checkOutput("rst_wr", {7'd0, imem_wr_en[d], imem_wr_addr[d], imem_wr_data[d]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic load");
        loadBasic();
        applyStimulus(2, 8'h48, 1'b0, 0);

        $display("[TB] bad checksum");
        applyStimulus(2, 8'h49, 1'b0, 0);

        $display("[TB] illegal counts");
        applyLenErr(0);
        applyLenErr(257);

        $display("[TB] backpressure");
        gap_en = 1'b1;
        applyStimulus(2, 8'h48, 1'b0, 0);

        $display("[TB] start while busy");
        applyStimulus(2, 8'h48, 1'b1, 0);

        $display("[TB] reset mid-load and restart");
        gap_en = 1'b0;
        applyStimulus(2, 8'h48, 1'b0, 4);
        applyStimulus(2, 8'h48, 1'b0, 0);

        $display("[TB] random loads");
        gap_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n;
            logic [7:0] c;
            n = $urandom_range(1, 8);
            for (int i = 0; i < 3 * n; i++) begin
                stim_bytes[i] = 8'($urandom_range(0, 255));
            end
            c = xorOf(n);
            if ($urandom_range(0, 1) == 0) begin
                c = c ^ 8'($urandom_range(1, 255));
            end
            applyStimulus(n, c, 1'b0, 0);
        end

        $display("[TB] full-depth load");
        gap_en = 1'b0;
        for (int i = 0; i < 768; i++) begin
            stim_bytes[i] = 8'($urandom_range(0, 255));
        end
        applyStimulus(256, xorOf(256), 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the RISC instruction memory: converts a byte stream from a host or bench into 24-bit instruction words and writes them sequentially into instruction memory.
- Holds the processor core in reset (cpu_hold) while loading. Releases it only after a verified XOR checksum.
- Sits between the external load channel and the instruction-memory write port, replacing hardcoded program images.

Parameters:
- ADDR_W, 8, instruction memory address width (depth 2^ADDR_W words).
- BASE_ADDR, 0, first write address of a load.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  single-cycle request to begin a load.
- count  input  ADDR_W+1  number of instructions to load; sampled on accepted start.
- in_data  input  8  load byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_wr_en  output  1  instruction memory write strobe, one cycle per word.
- imem_wr_addr  output  ADDR_W  write address.
- imem_wr_data  output  24  instruction word {opcode, fields, imm}.
- cpu_hold  output  1  core reset request; 1 = hold core.
- busy  output  1  load in progress.
- done  output  1  load finished, checksum good (level).
- chk_err  output  1  checksum mismatch (level).
- len_err  output  1  illegal count (level).

Behaviour:
- Reset (reset=0, async), all outputs registered:
  - state=IDLE.
  - cpu_hold=1.
  - in_ready, imem_wr_en, busy, done, chk_err and len_err = 0.
  - imem_wr_addr=0, imem_wr_data=0.
  - Internal index and XOR accumulator = 0.
- States: IDLE, B0, B1, B2, WRITE, CHK, DONE, ERR.
- Byte accept: a byte is accepted only when in_valid and in_ready are both 1 at a rising edge. in_ready=1 only in B0, B1, B2 and CHK.
- start handling:
  - Honoured only in IDLE, DONE or ERR. Ignored while busy=1.
  - Accepted start latches count and sets busy=1 and cpu_hold=1.
  - It clears done, chk_err, len_err, index and XOR.
  - If count==0 or count>2^ADDR_W: next state ERR with len_err=1. Otherwise next state B0.
- Word assembly: B0 byte → word[23:16], B1 → [15:8], B2 → [7:0]. Every data byte is XORed into the accumulator.
- WRITE: entered the cycle after the B2 accept; lasts one cycle.
  - imem_wr_en=1, imem_wr_addr=(BASE_ADDR+index) mod 2^ADDR_W, imem_wr_data=assembled word.
  - in_ready=0. index increments.
  - Next state is CHK if index+1==count, otherwise B0.
- CHK: accepts one checksum byte and compares it with the accumulator.
  - Equal → DONE: done=1, busy=0, cpu_hold=0.
  - Not equal → ERR: chk_err=1, busy=0, cpu_hold stays 1.
- DONE and ERR persist until a new start or reset. A new start re-asserts cpu_hold.
- imem_wr_en=0 in every state except WRITE. Address and data hold their last values otherwise.
- Throughput: minimum 4 cycles per instruction. Backpressure is via in_valid only; no byte is dropped or duplicated.
- Reset mid-load returns to IDLE immediately. Words already written are not undone.

Test Plan:
- Basic load:
  - Stimulus: BASE_ADDR=0, count=2, bytes 1A 2B 3C 40 00 05, checksum 48.
  - Required: writes 0x1A2B3C@0x00 and 0x400005@0x01. done=1 the cycle after the checksum accept. cpu_hold falls to 0. Exactly 2 imem_wr_en pulses.
- Bad checksum:
  - Stimulus: same stream with checksum 49.
  - Required: chk_err=1, done=0, cpu_hold=1. Both words are still written.
- Illegal count:
  - Stimulus: count=0, then count=257 with ADDR_W=8.
  - Required: len_err=1 one cycle after start. No write. in_ready stays 0.
- Backpressure:
  - Stimulus: in_valid toggled 1/0 randomly; a byte is presented during WRITE.
  - Required: in_ready=0 in WRITE. The presented byte is held and accepted in B0. Data is identical to the basic-load test.
- Address wrap:
  - Stimulus: BASE_ADDR=8'hFF, count=2.
  - Required: write addresses 0xFF then 0x00.
- Reset and restart:
  - Stimulus: reset=0 after 4 bytes accepted, then release reset and repeat the basic-load test.
  - Required: all outputs return to reset values asynchronously (cpu_hold=1). The second load completes with done=1 and correct words.
- Start while busy:
  - Stimulus: pulse start in B1.
  - Required: the pulse is ignored and the load continues unchanged.
